// File: rtl/deserializador_param_pkg.sv
// deser_pkg: shared state encoding for the serial-to-parallel front end
package deser_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SHIFT    = 2'd1;
    localparam logic [1:0] ST_PARITY   = 2'd2;
    localparam logic [1:0] ST_WAIT_ACK = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        SHIFT    = ST_SHIFT,
        PARITY   = ST_PARITY,
        WAIT_ACK = ST_WAIT_ACK
    } deser_state_t;

endpackage

// File: rtl/deserializador_param_contador_bits.sv
// contador_bits: W-bit synchronous up-counter with clear and enable, active-low sync reset
module contador_bits #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    // reset beats clear, clear beats count
    always_ff @(posedge clk) begin
        if (!rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en)
            q <= q + W'(1);
    end

endmodule

// File: rtl/deserializador_param.sv
// deserializador_param: assembles an N-bit word (MSB first) from a serial stream and offers it
// with valid/ready; load drives the en of the downstream parallel register, word its d.
// Optional even-parity bit after the data enabled by defining DESER_PARITY_EN.
module deserializador_param
    import deser_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sin,
    input  logic         bit_valid,
    input  logic         out_ready,
    output logic [N-1:0] word,
    output logic         out_valid,
    output logic         load,
    output logic         busy,
    output logic         parity_err
);

    localparam int CW = $clog2(N);

`ifdef DESER_PARITY_EN
    localparam deser_state_t AFTER_DATA = PARITY;
`else
    localparam deser_state_t AFTER_DATA = WAIT_ACK;
`endif

    deser_state_t  state;
    logic [N-1:0]  shreg;
    logic [CW-1:0] count;
    logic          take;
    logic          last;
    logic          clr;

    // a bit is consumed only while shifting; the Nth one also rewinds the counter
    assign take = (state == SHIFT) && bit_valid;
    assign last = take && (count == CW'(N - 1));
    assign clr  = ((state == IDLE) && start) || last;

    contador_bits #(.W(CW)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .en  (take),
        .q   (count)
    );

    assign word = shreg;
    assign load = out_valid & out_ready;

    // control FSM plus shift register; out_valid and busy are registered alongside the state
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            shreg     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= SHIFT;
                    shreg <= '0;
                    busy  <= 1'b1;
                end
                SHIFT: if (bit_valid) begin
                    shreg <= {shreg[N-2:0], sin};
                    if (last) begin
                        state     <= AFTER_DATA;
                        out_valid <= (AFTER_DATA == WAIT_ACK);
                    end
                end
                PARITY: if (bit_valid) begin
                    state     <= WAIT_ACK;
                    out_valid <= 1'b1;
                end
                WAIT_ACK: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DESER_PARITY_EN
    // even parity over data plus parity bit; sticky until the next accepted start
    always_ff @(posedge clk) begin
        if (!rst)
            parity_err <= 1'b0;
        else if ((state == IDLE) && start)
            parity_err <= 1'b0;
        else if ((state == PARITY) && bit_valid)
            parity_err <= (^shreg) ^ sin;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_deserializador_param.sv
// tb_deserializador_param: directed vectors checked against an arithmetic model of the deserializer
module tb_deserializador_param;

    localparam int N = 8;
`ifdef DESER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         sin = 1'b0;
    logic         bit_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [N-1:0] word;
    logic         out_valid;
    logic         load;
    logic         busy;
    logic         parity_err;

    int total = 0;
    int bad = 0;
    int load_cnt = 0;
    int l0 = 0;

    // model: phase 0 idle, 1 collecting, 2 awaiting parity, 3 presenting
    int m_phase = 0;
    int m_val = 0;
    int m_n = 0;
    bit m_perr = 1'b0;
    bit m_clean = 1'b0;
    bit chk = 1'b0;

    always #5 clk = ~clk;

    deserializador_param #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sin        (sin),
        .bit_valid  (bit_valid),
        .out_ready  (out_ready),
        .word       (word),
        .out_valid  (out_valid),
        .load       (load),
        .busy       (busy),
        .parity_err (parity_err)
    );

    always @(posedge clk) begin
        if (!rst) begin
            chk     <= 1'b1;
            m_phase <= 0;
            m_val   <= 0;
            m_n     <= 0;
            m_perr  <= 1'b0;
            m_clean <= 1'b1;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase <= 1;
                    m_val   <= 0;
                    m_n     <= 0;
                    m_perr  <= 1'b0;
                    m_clean <= 1'b0;
                end
                1: if (bit_valid) begin
                    m_val <= (m_val * 2 + int'(sin)) % 256;
                    m_n   <= m_n + 1;
                    if (m_n == N - 1) m_phase <= PAR ? 2 : 3;
                end
                2: if (bit_valid) begin
                    m_perr  <= ((($countones(m_val) + int'(sin)) % 2) == 1);
                    m_phase <= 3;
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic check_cycle();
        if (chk) begin
            cmp("busy", 32'(busy), 32'(m_phase != 0));
            cmp("out_valid", 32'(out_valid), 32'(m_phase == 3));
            cmp("load", 32'(load), 32'((m_phase == 3) && out_ready));
            cmp("parity_err", 32'(parity_err), 32'(m_perr));
            if (m_phase == 3 || m_clean) cmp("word", 32'(word), 32'(m_val));
            if (load === 1'b1) load_cnt++;
        end
    endtask

    task automatic cyc(input logic r, input logic st, input logic s, input logic bv, input logic rdy);
        @(negedge clk);
        rst = r;
        start = st;
        sin = s;
        bit_valid = bv;
        out_ready = rdy;
        #2;
        check_cycle();
    endtask

    task automatic send_bits(input logic [N-1:0] v, input logic rdy);
        for (int i = N - 1; i >= 0; i--) cyc(1'b1, 1'b0, v[i], 1'b1, rdy);
    endtask

    task automatic par_bit(input logic pb, input logic rdy);
        if (PAR) cyc(1'b1, 1'b0, pb, 1'b1, rdy);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        cmp("rst_busy", 32'(busy), 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cmp("rst_word", 32'(word), 32'h0);
        cmp("rst_valid", 32'(out_valid), 32'h0);

        l0 = load_cnt;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        send_bits(8'hA5, 1'b1);
        par_bit(1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cmp("a5_word", 32'(word), 32'hA5);
        cmp("a5_model", 32'(m_val), 32'hA5);
        cmp("a5_load", 32'(load), 32'h1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cmp("a5_loads", 32'(load_cnt - l0), 32'h1);
        cmp("a5_idle", 32'(busy), 32'h0);

        l0 = load_cnt;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        par_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            cmp("3c_word", 32'(word), 32'h3C);
            cmp("3c_valid", 32'(out_valid), 32'h1);
        end
        cmp("3c_noload", 32'(load_cnt - l0), 32'h0);
        cmp("3c_model", 32'(m_val), 32'h3C);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cmp("3c_loads", 32'(load_cnt - l0), 32'h1);

        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cmp("midrst_busy", 32'(busy), 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        send_bits(8'hFF, 1'b1);
        par_bit(1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cmp("ff_word", 32'(word), 32'hFF);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        l0 = load_cnt;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        par_bit(1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cmp("96_word", 32'(word), 32'h96);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cmp("96_hold", 32'(word), 32'h96);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cmp("96_idle", 32'(busy), 32'h0);
        cmp("96_loads", 32'(load_cnt - l0), 32'h1);

        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        send_bits(8'h81, 1'b1);
        par_bit(1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cmp("81_word", 32'(word), 32'h81);
        cmp("81_model", 32'(m_val), 32'h81);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef DESER_PARITY_EN
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(8'hA5, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cmp("par0_err", 32'(parity_err), 32'h0);
        cmp("par0_valid", 32'(out_valid), 32'h1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        l0 = load_cnt;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(8'hA5, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cmp("par1_err", 32'(parity_err), 32'h1);
        cmp("par1_word", 32'(word), 32'hA5);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cmp("par1_loads", 32'(load_cnt - l0), 32'h1);
        cmp("par1_sticky", 32'(parity_err), 32'h1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cmp("par_clear", 32'(parity_err), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/deserializador_param.md
Name: deserializador_param

Overview:
- Serial-to-parallel front end that assembles an N-bit word from a 1-bit serial stream.
- Presents the word with a valid/ready handshake.
- Produces a single-cycle load strobe that drives the enable and data of the downstream N-bit parallel register in the FSM Estructural datapath.
- Sits directly upstream of that register. `word` connects to the register's d input and `load` connects to its en input.

Parameters:
- N, 8, word width in bits; legal range N >= 2.
- CW, $clog2(N), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  single system clock; all state updates on rising edge
- rst  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
- start  input  1  request to begin capturing a word; sampled only in IDLE
- sin  input  1  serial data bit
- bit_valid  input  1  sin carries a valid bit this cycle
- out_ready  input  1  downstream accepts the word this cycle
- word  output  N  assembled word, MSB received first
- out_valid  output  1  word complete and stable
- load  output  1  one-cycle strobe = out_valid & out_ready; feeds register en
- busy  output  1  high in any state other than IDLE
- parity_err  output  1  parity result for the last word (see Optional Feature)

Behaviour:
- Reset (rst=0 at a rising edge):
  - state=IDLE, shift register=0, count=0, parity_err=0.
  - word=0, out_valid=0, load=0, busy=0.
  - Reset overrides every other input, including mid-SHIFT and mid-WAIT_ACK; a partial word is discarded.
- States: IDLE, SHIFT, WAIT_ACK (plus PARITY only with the macro).
- IDLE:
  - start=1 -> SHIFT next cycle, count cleared to 0, shift register cleared.
  - bit_valid and sin are ignored in IDLE, including a bit presented in the same cycle as start.
- SHIFT:
  - On a cycle with bit_valid=1: shreg <= {shreg[N-2:0], sin}, count <= count+1.
  - On a cycle with bit_valid=0: shreg and count hold. Gaps of any length are allowed.
  - When bit_valid=1 and count==N-1, the Nth bit is taken and the block goes to WAIT_ACK.
  - start is ignored while in SHIFT.
- WAIT_ACK:
  - out_valid=1; word = shreg, held stable until the handshake.
  - load = out_valid & out_ready, combinational and exactly one cycle wide.
  - out_ready=1 -> IDLE next cycle.
  - start in the same cycle as the handshake is ignored; back-to-back words cost one IDLE cycle.
  - bit_valid is ignored in WAIT_ACK (no back-pressure on the serial side; the source must not send).
- Latency: out_valid rises on the cycle after the Nth accepted bit. The minimum from start to out_valid is N+1 cycles.
- word is registered; its value outside WAIT_ACK is the current shreg (don't-care for consumers).
- count never exceeds N-1; there is no wrap-around inside a word.

Optional Feature:
- Macro: DESER_PARITY_EN.
- Defined:
  - After the Nth data bit the FSM enters PARITY instead of WAIT_ACK.
  - The next bit_valid bit is an even-parity bit: parity_err <= (^shreg) ^ sin, then the FSM goes to WAIT_ACK.
  - parity_err holds until the next start accepted in IDLE, which clears it.
  - A word with a parity error is still presented and loaded; the consumer decides what to do with it.
  - Minimum start-to-out_valid latency becomes N+2 cycles.
- Undefined: no PARITY state; parity_err is tied to 0.

Decomposition:
- Package deser_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, PARITY, WAIT_ACK} deser_state_t
  - the state-encoding constants
- Sub-module contador_bits #(W): synchronous up-counter with clear, en, and active-low synchronous rst. It is instantiated once for the bit count.
- The FSM and the shift register stay in the top module.

Test Plan (N=8):
- Reset: hold rst=0 for 3 cycles with start=1 and bit_valid=1 -> busy=0, out_valid=0, load=0, word=8'h00 throughout and after release.
- Basic word: start, then 8 consecutive bit_valid bits 1,0,1,0,0,1,0,1 with out_ready=1 -> out_valid and load high for exactly one cycle, word=8'hA5, then IDLE.
- Gaps and back-pressure:
  - Stimulus: bits of 8'h3C with bit_valid=0 gaps of 1 and 3 cycles, and out_ready held 0 for 5 cycles.
  - Required: word=8'h3C stable and out_valid=1 for all 5 cycles, load=0.
  - Then out_ready=1 -> load for exactly 1 cycle.
- Mid-operation reset: rst=0 after 4 bits -> next cycle busy=0. A new start plus 8'hFF -> word=8'hFF, with no residue from the partial word.
- Ignored inputs:
  - start pulses during SHIFT and WAIT_ACK do not restart or shorten the word.
  - A bit presented with start in IDLE is not captured: 9 bits 1,1,0,0,0,0,0,0,1 starting on the start cycle -> word=8'h81.
- DESER_PARITY_EN:
  - 8'hA5 with parity bit 0 -> parity_err=0.
  - 8'hA5 with parity bit 1 -> parity_err=1 and the word is still loaded.
  - The next start clears parity_err.
